// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store front end:
// access size encodings, FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Halfwords need an even offset, words a zero offset.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        return ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; lanes are little-endian (offset 0 = bits 7:0).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the read word.
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane; word loads pass straight through.
    always_comb begin
        load_data = 32'h0;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = is_unsigned ? {16'h0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    // Overwrite only the addressed lane, keep the rest of the word.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            SZ_WORD: merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide single-port data memory.
// Sub-word stores are done as read-modify-write through mem_lane_align.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [1:0]  op_offset;
    logic [31:0] op_wdata;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        req_err;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = misaligned(req_size, req_addr[1:0]) ||
                       (req_size == SZ_RSVD);

    mem_lane_align u_align (
        .word        (mem_out),
        .offset      (op_offset),
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .wdata       (op_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    // FSM, read-latency counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lat_cnt     <= 2'd0;
            op_we       <= 1'b0;
            op_size     <= SZ_BYTE;
            op_unsigned <= 1'b0;
            op_offset   <= 2'd0;
            op_wdata    <= 32'h0;
            mem_address <= '0;
            mem_we      <= 1'b0;
            mem_in      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_we       <= req_we;
                        op_size     <= req_size;
                        op_unsigned <= req_unsigned;
                        op_offset   <= req_addr[1:0];
                        op_wdata    <= req_wdata;
                        mem_address <= req_addr[ADDR_WIDTH+1:2];
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= ST_RESP;
                        end else if (req_we && req_size == SZ_WORD) begin
                            mem_in <= req_wdata;
                            mem_we <= 1'b1;
                            state  <= ST_WRITE;
                        end else begin
                            lat_cnt <= 2'(RD_LAT - 1);
                            state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else if (op_we) begin
                        mem_in <= merged;
                        mem_we <= 1'b1;
                        state  <= ST_WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random test of mem_access_unit against a byte-array
// reference model, with a word memory standing in for datamemory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_address;
    logic        mem_we;
    logic [31:0] mem_in;
    logic [31:0] mem_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [1024];
    logic [7:0]  refb [4096];

    bit          hs_on = 0;
    logic [31:0] hs_q [$];
    int          hs_bad = 0;

    mem_access_unit #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .RD_LAT     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_in       (mem_in),
        .mem_out      (mem_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Data memory stand-in: asynchronous read, synchronous write.
    assign mem_out = dmem[mem_address];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_address] <= mem_in;
    end

    // Handshake-phase monitor: collect responses, flag busy-state readiness.
    always @(negedge clk) begin
        if (hs_on && rsp_valid) hs_q.push_back(rsp_rdata);
        if (hs_on && (rsp_valid || mem_we) && req_ready) hs_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] size,
                                   input logic [11:0] a);
        int ai = int'(a);
        return (size == 2'd3) || (size == 2'd1 && ai % 2 != 0) ||
               (size == 2'd2 && ai % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_word(input int wi);
        return 32'(refb[wi*4]) + 32'(refb[wi*4+1]) * 256 +
               32'(refb[wi*4+2]) * 65536 + 32'(refb[wi*4+3]) * 16777216;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size,
                                             input bit uns,
                                             input logic [11:0] a);
        int ai = int'(a);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = 32'(refb[ai]);
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = 32'(refb[ai]) + 32'(refb[ai+1]) * 256;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = ref_word(ai / 4);
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [11:0] a,
                             input logic [31:0] d);
        int ai = int'(a);
        int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) refb[ai+k] = d[8*k +: 8];
    endtask

    // One full request: issue, follow it to its response, check everything.
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] got_data);
        bit          e;
        int          lat;
        int          cyc;
        int          wes;
        bit          got;
        logic [31:0] exp_data;
        e = ref_err(size, a);
        lat = e ? 1 : (we && size != 2'd2) ? 3 : 2;
        exp_data = 32'h0;
        if (!e && !we) exp_data = ref_load(size, uns, a);
        if (!e && we) ref_store(size, a, d);
        got_data = 32'hx;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 0;
        cyc = 0; wes = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (mem_we) begin
                wes++;
                chk("we_addr", 32'(mem_address), 32'(a[11:2]));
                chk("we_data", mem_in, ref_word(int'(a[11:2])));
            end
            if (rsp_valid) begin
                got = 1;
                got_data = rsp_rdata;
                chk("latency", cyc, lat);
                chk("rsp_err", 32'(rsp_err), 32'(e));
                chk("rsp_rdata", rsp_rdata, exp_data);
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("we_pulses", wes, (!e && we) ? 1 : 0);
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] r;
    logic [31:0] hs_data [16];
    int          n;

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) refb[i] = 8'h0;
        rst_n = 0; req_valid = 0; req_we = 0; req_size = 0;
        req_unsigned = 0; req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_address", 32'(mem_address), 32'h0);
        chk("rst_mem_in", mem_in, 32'h0);
        rst_n = 1;

        do_req(1, 2'd2, 0, 12'h010, 32'hDEADBEEF, r);
        do_req(0, 2'd2, 0, 12'h010, 0, r);
        chk("lw_deadbeef", r, 32'hDEADBEEF);

        do_req(1, 2'd0, 0, 12'h012, 32'h55, r);
        chk("sb_word", dmem[4], 32'hDE55BEEF);
        do_req(0, 2'd0, 0, 12'h013, 0, r);
        chk("lb_sign", r, 32'hFFFFFFDE);
        do_req(0, 2'd0, 1, 12'h013, 0, r);
        chk("lbu_zero", r, 32'h000000DE);

        do_req(1, 2'd2, 0, 12'h014, 32'h12345678, r);
        do_req(1, 2'd1, 0, 12'h016, 32'h8001, r);
        chk("sh_word", dmem[5], 32'h80015678);
        do_req(0, 2'd1, 0, 12'h016, 0, r);
        chk("lh_sign", r, 32'hFFFF8001);
        do_req(0, 2'd1, 1, 12'h016, 0, r);
        chk("lhu_zero", r, 32'h00008001);

        do_req(0, 2'd2, 0, 12'h012, 0, r);
        do_req(1, 2'd1, 0, 12'h011, 32'hFFFF, r);
        do_req(1, 2'd3, 0, 12'h010, 32'h1, r);
        chk("err_no_write", dmem[4], 32'hDE55BEEF);

        // Continuous req_valid across 16 stores and 16 loads.
        hs_q.delete();
        hs_on = 1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            req_valid = 1;
            req_size = 2'd2;
            req_unsigned = 0;
            req_addr = 12'((i % 16) * 4);
            if (i < 16) begin
                hs_data[i] = $urandom;
                req_we = 1;
                req_wdata = hs_data[i];
                ref_store(2'd2, req_addr, hs_data[i]);
            end else begin
                req_we = 0;
                req_wdata = 0;
            end
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("hs_ready_wait", 32'(req_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 0;
        repeat (6) @(negedge clk);
        hs_on = 0;
        chk("hs_rsp_count", hs_q.size(), 32);
        chk("hs_ready_busy", hs_bad, 0);
        if (hs_q.size() == 32) begin
            for (int i = 0; i < 16; i++) begin
                chk("hs_store_rsp", hs_q[i], 32'h0);
                chk("hs_load_rsp", hs_q[16+i], hs_data[i]);
            end
        end

        // Reset while a sub-word store is in READ.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd0;
        req_unsigned = 0; req_addr = 12'h021; req_wdata = 32'hA5;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_addr", 32'(mem_address), 32'h0);
        chk("mid_rst_in", mem_in, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);
            chk("rst_hold_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1;
        chk("rst_word_kept", dmem[8], ref_word(8));
        do_req(0, 2'd0, 1, 12'h021, 0, r);
        do_req(1, 2'd0, 0, 12'h021, 32'h3C, r);
        do_req(0, 2'd0, 1, 12'h021, 0, r);
        chk("post_rst_lbu", r, 32'h3C);

        // Random mix of sizes, offsets and signedness over words 0..15.
        for (int i = 0; i < 200; i++) begin
            do_req(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), 12'($urandom_range(0, 63)),
                   $urandom, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the MIPS CPU data memory. Accepts byte/halfword/word load and store requests from the execute/memory stage over a valid/ready handshake and converts them into word-wide accesses on the single-port `datamemory`. Sub-word stores use read-modify-write. Loads return sign- or zero-extended data with a one-cycle response pulse. The block sits between the CPU pipeline and `datamemory`, and is the only driver of its `address`/`we`/`in` ports.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address width of the data memory.
- DATA_WIDTH, 32: word width; must be 32.
- RD_LAT, 1: clock edges from `mem_address` being driven to `mem_out` being sampled; legal range 1–3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (flagged as an error).
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or reserved size; qualified by rsp_valid.
- mem_address  out  ADDR_WIDTH  connects to datamemory `address`.
- mem_we  out  1  connects to datamemory `we`.
- mem_in  out  32  connects to datamemory `in`.
- mem_out  in  32  connects to datamemory `out`.

## Operation
- Request acceptance: a request is accepted on a rising edge where req_valid && req_ready. All request fields are latched at that edge.
- Addressing: word index = req_addr[ADDR_WIDTH+1:2], lane offset = req_addr[1:0].
- Byte lanes: little-endian lanes; offset 0 is bits 7:0.
- Misalignment: half with offset[0]=1, or word with offset≠0, is misaligned. Size 11 is an error.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → RESP on accept if error. No memory access occurs and mem_we stays 0.
  - IDLE → READ on a load or a sub-word store.
  - IDLE → WRITE on a word store.
  - READ holds for RD_LAT cycles, then samples mem_out. A load goes to RESP; a sub-word store goes to WRITE with the merged word.
  - WRITE: mem_we=1 for exactly one cycle, then RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- Load extract: select the lane, then extend. Signed byte takes bit 7 as sign; signed half takes bit 15. req_unsigned forces zero fill. Word loads ignore req_unsigned.
- Store merge: replace only the addressed 8/16-bit lane of the read word with req_wdata[7:0] or [15:0]. Other lanes are unchanged.
- No back-pressure on the response side; the consumer must take rsp_valid when it occurs.

## Timing
- Output registers: mem_address, mem_we, mem_in, rsp_* are registered. req_ready is decoded from the state register.
- Reset values (on rst_n low): state IDLE, mem_address 0, mem_we 0, mem_in 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1.
- Latency, counted from the accept edge (cycle 0) with RD_LAT=1:
  - error: rsp_valid in cycle 1.
  - word store: WRITE in cycle 1, rsp_valid in cycle 2.
  - load: READ in cycle 1, rsp_valid in cycle 2.
  - sub-word store: READ in cycle 1, WRITE in cycle 2, rsp_valid in cycle 3.
  - Each extra RD_LAT cycle adds one cycle to the READ paths.
- Address stability: mem_address is stable from the accept edge until the edge leaving WRITE/RESP.
- Back-to-back: the earliest next accept is the cycle after RESP; minimum 2 cycles between accepts.
- Reset mid-operation: mem_we falls asynchronously, an in-flight write may be lost, and no response is issued.
- req_valid while not ready is ignored. The requester holds the request until it is accepted.

## Structure
- Shared package `mem_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - function `misaligned(size, offset)`.
- One sub-module: `mem_lane_align`, purely combinational. It contains the load extract/extend and the store lane merge. The top level holds the FSM, RD_LAT counter and registers.

## Test plan
- Word store: addr 0x010, data 0xDEADBEEF; then word load at 0x010 → mem_we pulse at word 4 in cycle 1; load rsp_rdata 0xDEADBEEF, rsp_err 0.
- Byte store: word 4 = 0xDEADBEEF; sb 0x55 at byte 0x012 → written word 0xDE55BEEF; lb at 0x013 → 0xFFFFFFDE; lbu at 0x013 → 0x000000DE.
- Halfword: sh 0x8001 at 0x016 → word 5 bits 31:16 = 0x8001, lower half unchanged; lh → 0xFFFF8001; lhu → 0x00008001.
- Errors: lw at 0x012, sh at 0x011, size 11 → rsp_err=1 in cycle 1, rsp_rdata 0, mem_we never asserted.
- Handshake: hold req_valid continuously with 16 stores followed by 16 loads, addresses 0–15 × 4 → req_ready low outside IDLE, exactly one rsp_valid per request, readback matches.
- Reset: assert rst_n low in the READ cycle of a sub-word store → mem_we stays 0, all outputs at reset values, next request serviced normally.
